// File: rtl/mul_by255_seq.sv
// Sequential X*255 over a 16-bit bus: P = (X<<8) - X, one 16-bit slice per cycle with a borrow chain.
// Optional MUL255_SAT32_EN clamps P to 32 bits and flags ovf on overflow.
module mul_by255_seq #(
    parameter int DW = 16,
    parameter int XW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          ld_hi,
    input  logic          ld_lo,
    input  logic          start,
    input  logic [1:0]    rd_sel,
    output logic [DW-1:0] dout,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SUB0 = 3'd1,
        S_SUB1 = 3'd2,
        S_SUB2 = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XW-1:0]   r_x;
    logic [39:0]     r_p;
    logic            r_borrow;

    logic            w_idle_like;
    logic            w_load;
    logic            w_go;
    logic            w_ovf;
    logic [39:0]     w_m;
    logic [39:0]     w_s;
    logic [16:0]     w_diff0;
    logic [16:0]     w_diff1;
    logic [7:0]      w_diff2;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_load      = w_idle_like && (ld_hi || ld_lo);
    // A load in the same cycle as start wins, so X never changes under a running operation.
    assign w_go        = w_idle_like && start && !(ld_hi || ld_lo);

    assign w_m     = {r_x, 8'h00};
    assign w_s     = {8'h00, r_x};
    assign w_diff0 = {1'b0, w_m[15:0]}  - {1'b0, w_s[15:0]};
    assign w_diff1 = {1'b0, w_m[31:16]} - {1'b0, w_s[31:16]} - {16'b0, r_borrow};
    assign w_diff2 = w_m[39:32] - w_s[39:32] - {7'b0, r_borrow};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_go) w_state_nxt = S_SUB0;
            S_SUB0: w_state_nxt = S_SUB1;
            S_SUB1: w_state_nxt = S_SUB2;
            S_SUB2: w_state_nxt = S_DONE;
            S_DONE: begin
                if (w_load)    w_state_nxt = S_IDLE;
                else if (w_go) w_state_nxt = S_SUB0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef MUL255_SAT32_EN
    logic r_ovf;
    assign w_ovf = r_ovf;
`else
    assign w_ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_p      <= '0;
            r_borrow <= 1'b0;
`ifdef MUL255_SAT32_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                if (ld_hi) r_x[31:16] <= din;
                if (ld_lo) r_x[15:0]  <= din;
            end
`ifdef MUL255_SAT32_EN
            if (w_go) r_ovf <= 1'b0;
`endif
            case (r_state)
                S_SUB0: begin
                    r_p[15:0] <= w_diff0[15:0];
                    r_borrow  <= w_diff0[16];
                end
                S_SUB1: begin
                    r_p[31:16] <= w_diff1[15:0];
                    r_borrow   <= w_diff1[16];
                end
                S_SUB2: begin
`ifdef MUL255_SAT32_EN
                    // Top byte is never exposed in clamped mode; any nonzero value means overflow.
                    r_p[39:32] <= 8'h00;
                    if (w_diff2 != 8'h00) begin
                        r_p[31:0] <= 32'hFFFF_FFFF;
                        r_ovf     <= 1'b1;
                    end
`else
                    r_p[39:32] <= w_diff2;
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_SUB0) || (r_state == S_SUB1) || (r_state == S_SUB2);
    assign done = (r_state == S_DONE);

    always_comb begin
        dout = '0;
        case (rd_sel)
            2'd0:    dout = r_p[15:0];
            2'd1:    dout = r_p[31:16];
            2'd2:    dout = {{(DW-8){1'b0}}, r_p[39:32]};
            default: dout = {{(DW-3){1'b0}}, w_ovf, busy, done};
        endcase
    end

endmodule

// File: tb/tb_mul_by255_seq.sv
// Bench for mul_by255_seq: directed vector table, hand-written protocol/reset sequences, random operands vs. arithmetic model.
module tb_mul_by255_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        ld_hi, ld_lo, start;
    logic [1:0]  rd_sel;
    logic [15:0] dout;
    logic        busy, done;

    int n_checks = 0;
    int n_errors = 0;

    mul_by255_seq #(.DW(16), .XW(32)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .ld_hi(ld_hi), .ld_lo(ld_lo),
        .start(start), .rd_sel(rd_sel), .dout(dout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [15:0] e0, e1, e2, st;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic rd(input logic [1:0] sel, output logic [15:0] val);
        rd_sel = sel;
        #1;
        val = dout;
    endtask

    task automatic check_all(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] st);
        logic [15:0] v;
        rd(2'd0, v); check({tag, " sel0"}, {16'h0, v}, {16'h0, e0});
        rd(2'd1, v); check({tag, " sel1"}, {16'h0, v}, {16'h0, e1});
        rd(2'd2, v); check({tag, " sel2"}, {16'h0, v}, {16'h0, e2});
        rd(2'd3, v); check({tag, " status"}, {16'h0, v}, {16'h0, st});
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic load_x(input logic [31:0] x);
        ld_hi = 1'b1; din = x[31:16];
        @(negedge clk);
        ld_hi = 1'b0; ld_lo = 1'b1; din = x[15:0];
        @(negedge clk);
        ld_lo = 1'b0;
    endtask

    task automatic run_op(output int nb);
        nb = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            if (busy) nb++;
            @(negedge clk);
        end
    endtask

    function automatic void model(input logic [31:0] x, output logic [15:0] e0,
                                  output logic [15:0] e1, output logic [15:0] e2,
                                  output logic [15:0] st);
        logic [39:0] p;
        p  = {8'h00, x} * 40'd255;
        st = 16'h0001;
`ifdef MUL255_SAT32_EN
        if (p > 40'h00_FFFF_FFFF) begin
            p  = 40'h00_FFFF_FFFF;
            st = 16'h0005;
        end
`endif
        e0 = p[15:0];
        e1 = p[31:16];
        e2 = {8'h00, p[39:32]};
    endfunction

    vec_t vecs[6];

    initial begin
        int nb;
        logic [15:0] e0, e1, e2, st, v;
        logic [31:0] x;

        vecs[0] = '{32'd100,        16'h639C, 16'h0000, 16'h0000, 16'h0001};
        vecs[1] = '{32'd1000,       16'hE418, 16'h0003, 16'h0000, 16'h0001};
`ifdef MUL255_SAT32_EN
        vecs[2] = '{32'hFFFF_FFFF,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0005};
        vecs[4] = '{32'h0101_0102,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0005};
`else
        vecs[2] = '{32'hFFFF_FFFF,  16'hFF01, 16'hFFFF, 16'h00FE, 16'h0001};
        vecs[4] = '{32'h0101_0102,  16'h00FE, 16'h0000, 16'h0001, 16'h0001};
`endif
        vecs[3] = '{32'h0101_0101,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001};
        vecs[5] = '{32'h0000_0000,  16'h0000, 16'h0000, 16'h0000, 16'h0001};

        rst_n = 1'b0; din = '0; ld_hi = 0; ld_lo = 0; start = 0; rd_sel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all("reset", 16'h0, 16'h0, 16'h0, 16'h0);

        foreach (vecs[i]) begin
            load_x(vecs[i].x);
            run_op(nb);
            check($sformatf("vec%0d busy_cycles", i), nb, 3);
            check($sformatf("vec%0d done", i), {31'b0, done}, 1);
            check_all($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].st);
        end

        // Reset mid-SUB1 abandons the operation.
        load_x(32'd1000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre-reset busy", {31'b0, busy}, 1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all("midop reset", 16'h0, 16'h0, 16'h0, 16'h0);

        // Start and load while busy are ignored.
        load_x(32'd1000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b1; ld_lo = 1'b1; din = 16'h1234;
        @(negedge clk);
        start = 1'b0; ld_lo = 1'b0;
        for (int i = 0; i < 8 && !done; i++) @(negedge clk);
        check("busy-ignore done", {31'b0, done}, 1);
        check_all("busy-ignore", 16'hE418, 16'h0003, 16'h0000, 16'h0001);
        @(negedge clk);
        check("no queued start", {31'b0, busy}, 0);
        // Restart from DONE proves X was not altered by the ignored load.
        run_op(nb);
        check("restart busy_cycles", nb, 3);
        check_all("restart", 16'hE418, 16'h0003, 16'h0000, 16'h0001);

        // Load in DONE drops to IDLE but keeps P.
        ld_lo = 1'b1; din = 16'h0005;
        @(negedge clk);
        ld_lo = 1'b0;
        check_all("load in done", 16'hE418, 16'h0003, 16'h0000, 16'h0000);
        // Load+start together in IDLE: load only.
        ld_lo = 1'b1; start = 1'b1; din = 16'h0007;
        @(negedge clk);
        ld_lo = 1'b0; start = 1'b0;
        check("ld+start busy", {31'b0, busy}, 0);
        @(negedge clk);
        check("ld+start still idle", {30'b0, busy, done}, 0);
        run_op(nb);
        check_all("ld+start result", 16'h06F9, 16'h0000, 16'h0000, 16'h0001);

        for (int k = 0; k < 20; k++) begin
            x = $urandom;
            if (k % 4 == 0) x = x >> $urandom_range(31, 0);
            load_x(x);
            run_op(nb);
            model(x, e0, e1, e2, st);
            check($sformatf("rand%0d busy_cycles", k), nb, 3);
            check_all($sformatf("rand%0d x=%08h", k, x), e0, e1, e2, st);
        end

        rd(2'd3, v);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
